// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: machine word and the fetch-stage state encoding.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    HOLD   = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline latch feeding decode; clear wins over load, otherwise holds.
module if_id_reg
  import cpu_types_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  i_load,
  input  logic  i_clear,
  input  word_t i_instru,
  input  word_t i_npc,
  output word_t o_instru,
  output word_t o_npc,
  output logic  o_deen
);

  word_t r_instru;
  word_t r_npc;
  logic  r_deen;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_instru <= '0;
      r_npc    <= '0;
      r_deen   <= 1'b0;
    end else if (i_clear) begin
      // nPC is left alone: with deen=0 decode ignores it
      r_instru <= '0;
      r_deen   <= 1'b0;
    end else if (i_load) begin
      r_instru <= i_instru;
      r_npc    <= i_npc;
      r_deen   <= 1'b1;
    end
  end

  assign o_instru = r_instru;
  assign o_npc    = r_npc;
  assign o_deen   = r_deen;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, issues icache reads and drives the IF/ID latch,
// with a one-entry hold buffer for an instruction that returns during a stall.
//
// state  | meaning
// FETCH  | requesting from icache, latch updated from ihit
// HOLD   | one instruction buffered, waiting for stall to drop
// HALTED | fetch stopped until reset
module fetch_stage
  import cpu_types_pkg::*;
#(
  parameter word_t       PC_INIT = 32'h0000_0000,
  parameter int unsigned PC_INC  = 4
) (
  input  logic  CLK,
  input  logic  RST,
  input  logic  ihit,
  input  word_t iload,
  output logic  iREN,
  output word_t iaddr,
  input  logic  stall,
  input  logic  redirect,
  input  word_t redirect_pc,
  input  logic  halt,
  output word_t instru,
  output word_t nPC,
  output logic  deen,
  output logic  halted
);

  localparam word_t PC_STEP = PC_INC[31:0];

  fetch_state_t r_state;
  fetch_state_t w_next_state;
  word_t        r_pc;
  word_t        r_buf;
  word_t        r_bufpc;
  word_t        w_next_pc;
  word_t        w_pc_inc;
  word_t        w_lat_instr;
  word_t        w_lat_npc;
  logic         w_lat_load;
  logic         w_lat_clear;
  logic         w_buf_load;

  assign w_pc_inc = r_pc + PC_STEP;

  always_comb begin
    w_next_state = r_state;
    w_next_pc    = r_pc;
    w_lat_instr  = iload;
    w_lat_npc    = w_pc_inc;
    w_lat_load   = 1'b0;
    w_lat_clear  = 1'b0;
    w_buf_load   = 1'b0;
    if (r_state != HALTED) begin
      if (redirect) begin
        w_next_pc    = redirect_pc;
        w_lat_clear  = 1'b1;
        w_next_state = FETCH;
      end else if (halt) begin
        w_lat_clear  = 1'b1;
        w_next_state = HALTED;
      end else begin
        case (r_state)
          FETCH: begin
            if (ihit && stall) begin
              w_buf_load   = 1'b1;
              w_next_pc    = w_pc_inc;
              w_next_state = HOLD;
            end else if (ihit) begin
              w_lat_load = 1'b1;
              w_next_pc  = w_pc_inc;
            end else if (!stall) begin
              w_lat_clear = 1'b1;
            end
          end
          HOLD: begin
            if (!stall) begin
              w_lat_instr  = r_buf;
              w_lat_npc    = r_bufpc;
              w_lat_load   = 1'b1;
              w_next_state = FETCH;
            end
          end
          default: w_next_state = HALTED;
        endcase
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= FETCH;
      r_pc    <= PC_INIT;
      r_buf   <= '0;
      r_bufpc <= '0;
    end else begin
      r_state <= w_next_state;
      r_pc    <= w_next_pc;
      if (w_buf_load) begin
        r_buf   <= iload;
        r_bufpc <= w_pc_inc;
      end
    end
  end

  if_id_reg u_if_id (
    .clk      (CLK),
    .rst      (RST),
    .i_load   (w_lat_load),
    .i_clear  (w_lat_clear),
    .i_instru (w_lat_instr),
    .i_npc    (w_lat_npc),
    .o_instru (instru),
    .o_npc    (nPC),
    .o_deen   (deen)
  );

  assign iREN   = (r_state == FETCH) && !RST;
  assign iaddr  = r_pc;
  assign halted = (r_state == HALTED);

endmodule
